// File: rtl/sha_msg_packer.sv
// Packs an incoming byte stream into a single 440-bit SHA message block.
// Optional idle-timeout flush of partial messages: define SHA_MSG_TIMEOUT_EN.
module sha_msg_packer #(
  parameter int unsigned MAX_BYTES   = 55,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         in_ready,
  output logic         msg_valid,
  output logic [439:0] msg_word,
  output logic [5:0]   byte_valid,
  input  logic         hash_done,
  output logic         trunc_o
);

  localparam int unsigned WordW = 440;

  if (MAX_BYTES < 1 || MAX_BYTES > 55) begin : gen_bad_max
    $error("MAX_BYTES must be in 1..55");
  end
  if (TIMEOUT_CYC < 1) begin : gen_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StEmit,
    StWaitHash,
    StDrain
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         count_q, count_d;
  logic [WordW-1:0]   word_q, word_d;
  logic               trunc_q, trunc_d;
  logic               accept;
  logic               to_hit;
  logic [5:0]         max_cnt;

  assign max_cnt = 6'(MAX_BYTES);
  assign accept  = in_valid && in_ready;

`ifdef SHA_MSG_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

  logic [ToW-1:0] to_q, to_d;

  // Fires on the edge where the idle count would reach TIMEOUT_CYC.
  assign to_hit = (state_q == StCollect) && !accept && (to_q == ToW'(TIMEOUT_CYC - 1));

  always_comb begin
    to_d = to_q;
    if (accept) begin
      to_d = '0;
    end else if (state_q == StCollect && !to_hit) begin
      to_d = to_q + ToW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    trunc_d = trunc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Fresh message: wipe the previous payload so nothing stale survives.
          word_d              = '0;
          word_d[WordW-1 -: 8] = in_byte;
          count_d             = 6'd1;
          trunc_d             = 1'b0;
          if (in_last) begin
            state_d = StEmit;
          end else if (max_cnt == 6'd1) begin
            trunc_d = 1'b1;
            state_d = StDrain;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (accept) begin
          if (count_q < max_cnt) begin
            word_d[(WordW - 8) - 8 * int'(count_q) +: 8] = in_byte;
            count_d = count_q + 6'd1;
          end
          if (in_last) begin
            state_d = StEmit;
          end else if (count_q + 6'd1 >= max_cnt) begin
            trunc_d = 1'b1;
            state_d = StDrain;
          end
        end else if (to_hit) begin
          state_d = StEmit;
        end
      end
      StDrain: begin
        if (accept && in_last) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        state_d = StWaitHash;
      end
      StWaitHash: begin
        if (hash_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      word_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == StIdle) || (state_q == StCollect) || (state_q == StDrain);
    msg_valid  = (state_q == StEmit);
    msg_word   = word_q;
    byte_valid = count_q;
    trunc_o    = trunc_q;
  end

endmodule

// File: tb/tb_sha_msg_packer.sv
// Randomized bench for sha_msg_packer against a queue-based message model.
module tb_sha_msg_packer;

  localparam int unsigned MaxBytes   = 55;
  localparam int unsigned TimeoutCyc = 16;

  typedef byte unsigned bq_t[$];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         in_ready;
  logic         msg_valid;
  logic [439:0] msg_word;
  logic [5:0]   byte_valid;
  logic         hash_done;
  logic         trunc_o;

  sha_msg_packer #(
    .MAX_BYTES  (MaxBytes),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .msg_valid (msg_valid),
    .msg_word  (msg_word),
    .byte_valid(byte_valid),
    .hash_done (hash_done),
    .trunc_o   (trunc_o)
  );

  always #5 clk = ~clk;

  int unsigned  cyc = 0;
  int unsigned  n_chk = 0;
  int unsigned  n_bad = 0;
  int unsigned  pulse_cnt = 0;
  int unsigned  mv_cyc = 0;
  logic [439:0] cap_word = '0;
  logic [5:0]   cap_bv = '0;
  logic         cap_trunc = 1'b0;
  logic         cap_rdy = 1'b0;
  logic [439:0] prev_word = '0;
  int unsigned  prev_bv = 0;
  bit           have_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (msg_valid) begin
      pulse_cnt <= pulse_cnt + 1;
      cap_word  <= msg_word;
      cap_bv    <= byte_valid;
      cap_trunc <= trunc_o;
      cap_rdy   <= in_ready;
      mv_cyc    <= cyc;
    end
  end

  task automatic check(input string tag, input logic [439:0] got, input logic [439:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first `kept` bytes left-justified, byte 0 in the top octet.
  function automatic logic [439:0] pack(input bq_t b, input int unsigned kept);
    logic [439:0] w = '0;
    for (int i = 0; i < int'(kept); i++) begin
      w = w | ({432'd0, b[i]} << (8 * (54 - i)));
    end
    return w;
  endfunction

  task automatic send(input bq_t b, input bit with_last, output int unsigned acc_cyc);
    int n;
    acc_cyc = 0;
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid  = 1'b0;
        in_byte   = 8'($urandom);
        in_last   = 1'($urandom);
        hash_done = 1'($urandom);
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_byte   = b[i];
      in_last   = with_last && (i == b.size() - 1);
      hash_done = 1'($urandom);
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        check("ready_wait", 0, 1);
        break;
      end
      acc_cyc = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    hash_done = 1'b0;
  endtask

  task automatic expect_pulse(input int unsigned base, input int unsigned acc,
                              input int unsigned lat, input logic [439:0] w,
                              input int unsigned bv, input bit tr);
    int n = 0;
    #1;
    while (pulse_cnt == base && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("pulse_count", pulse_cnt, base + 1);
    check("latency", mv_cyc - acc, lat);
    check("msg_word", cap_word, w);
    check("byte_valid", cap_bv, bv);
    check("trunc", cap_trunc, tr);
    check("emit_ready", cap_rdy, 0);
  endtask

  // Hold off hash_done while offering a stray byte that must not be taken.
  task automatic finish_hash(input int unsigned base);
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      check("wait_ready", in_ready, 0);
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      in_last  = 1'b1;
    end
    @(negedge clk);
    check("wait_ready", in_ready, 0);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    hash_done = 1'b1;
    @(negedge clk);
    hash_done = 1'b0;
    check("done_ready", in_ready, 1);
    check("single_pulse", pulse_cnt, base + 1);
  endtask

  task automatic run_msg(input bq_t b);
    int unsigned base, acc, kept;
    logic [439:0] w;
    if (have_prev) begin
      check("hold_word", msg_word, prev_word);
      check("hold_bv", byte_valid, prev_bv);
    end
    kept = (b.size() > MaxBytes) ? MaxBytes : b.size();
    w    = pack(b, kept);
    base = pulse_cnt;
    send(b, 1'b1, acc);
    expect_pulse(base, acc, 1, w, kept, b.size() > MaxBytes);
    finish_hash(base);
    prev_word = w;
    prev_bv   = kept;
    have_prev = 1'b1;
  endtask

  initial begin
    bq_t          q;
    int unsigned  base, acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = '0;
    in_last   = 1'b0;
    hash_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", msg_valid, 0);
    check("rst_word", msg_word, 0);
    check("rst_bv", byte_valid, 0);
    check("rst_trunc", trunc_o, 0);

    q = '{8'h61, 8'h62, 8'h63};
    run_msg(q);

    q = {};
    for (int i = 0; i < 55; i++) q.push_back(8'(i));
    run_msg(q);

    q = {};
    for (int i = 0; i < 60; i++) q.push_back(8'($urandom_range(1, 255)));
    run_msg(q);

    q = '{8'hFF};
    run_msg(q);
    q = '{8'h61, 8'h62, 8'h63};
    run_msg(q);

    // Reset mid-message: partial payload must vanish without a pulse.
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'($urandom_range(1, 255)));
    base = pulse_cnt;
    send(q, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("async_word", msg_word, 0);
    check("async_bv", byte_valid, 0);
    check("async_trunc", trunc_o, 0);
    check("async_valid", msg_valid, 0);
    check("async_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_pulse", pulse_cnt, base);
    have_prev = 1'b0;
    q = '{8'h61, 8'h62, 8'h63};
    run_msg(q);

    for (int m = 0; m < 20; m++) begin
      int unsigned len = $urandom_range(1, 70);
      q = {};
      for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
      run_msg(q);
    end

    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    base = pulse_cnt;
    send(q, 1'b0, acc);
`ifdef SHA_MSG_TIMEOUT_EN
    expect_pulse(base, acc, TimeoutCyc + 1, pack(q, 4), 4, 1'b0);
    finish_hash(base);
`else
    repeat (40) @(negedge clk);
    check("no_timeout", pulse_cnt, base);
    begin
      bq_t tail;
      int unsigned acc2;
      tail = '{8'h55};
      send(tail, 1'b1, acc2);
      q.push_back(8'h55);
      expect_pulse(base, acc2, 1, pack(q, 5), 5, 1'b0);
      finish_hash(base);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/sha_msg_packer.md
SHA_MSG_PACKER -- requirements
Module: sha_msg_packer

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 55, giving the single-block payload capacity in bytes (legal range 1..55).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1000, giving the idle cycles before a partial-message flush; it is used only when SHA_MSG_TIMEOUT_EN is defined.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream byte valid (UART RX side).
REQ-006 in_byte  input  8  message byte.
REQ-007 in_last  input  1  qualifies in_byte as the final byte of the message.
REQ-008 in_ready  output  1  byte accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-009 msg_valid  output  1  one-cycle pulse presenting a packed message to the hash pipeline.
REQ-010 msg_word  output  440  packed message; first byte at [439:432]; unused low bytes are 0.
REQ-011 byte_valid  output  6  count of valid bytes in msg_word, 1..MAX_BYTES.
REQ-012 hash_done  input  1  completion pulse from the hash pipeline.
REQ-013 trunc_o  output  1  the current or last message exceeded MAX_BYTES and was truncated.

Function
REQ-014 The FSM SHALL have the states IDLE, COLLECT, EMIT, WAIT_HASH and DRAIN.
REQ-015 IDLE: in_ready=1; an accepted byte is stored at byte 0, count=1, trunc_o is cleared, and the FSM moves to COLLECT, or to EMIT if in_last=1.
REQ-016 COLLECT: in_ready=1; each accepted byte is written at index count (bits 439-8*count down to 432-8*count) and count increments.
REQ-017 COLLECT exit: accepting a byte with in_last=1 moves the FSM to EMIT.
REQ-018 COLLECT exit: accepting byte number MAX_BYTES with in_last=0 sets trunc_o and moves the FSM to DRAIN.
REQ-019 DRAIN: in_ready=1 and accepted bytes are discarded; the byte carrying in_last=1 moves the FSM to EMIT.
REQ-020 EMIT: in_ready=0; msg_valid=1 for exactly one cycle with byte_valid=count; the next state is WAIT_HASH.
REQ-021 msg_valid SHALL therefore rise one cycle after the in_last byte (or the timeout flush) is accepted.
REQ-022 msg_word and byte_valid SHALL hold stable from EMIT until the next message's first byte is accepted.
REQ-023 WAIT_HASH: in_ready=0; hash_done=1 returns the FSM to IDLE on the next edge.
REQ-024 hash_done asserted in any state other than WAIT_HASH SHALL be ignored.
REQ-025 The msg_word storage SHALL be cleared to 0 when the first byte of a new message is accepted, so stale bytes never leak into a message.
REQ-026 in_byte and in_last SHALL be ignored whenever in_valid=0.
REQ-027 count SHALL be 6 bits wide and SHALL never exceed MAX_BYTES; no wrap-around is permitted.

Reset
REQ-028 Asserting rst_n low SHALL, asynchronously: set the state to IDLE, count=0, msg_valid=0, msg_word=0, byte_valid=0, trunc_o=0.
REQ-029 in_ready SHALL be 1 after reset is released.
REQ-030 Reset asserted mid-message or in WAIT_HASH SHALL discard the partial message with no msg_valid pulse.

Configuration
REQ-031 With SHA_MSG_TIMEOUT_EN defined, a counter SHALL clear on every accepted byte and increment each cycle in COLLECT.
REQ-032 With SHA_MSG_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYC SHALL move the FSM to EMIT with the bytes collected so far.
REQ-033 With SHA_MSG_TIMEOUT_EN undefined, there SHALL be no timeout logic and COLLECT SHALL wait indefinitely for in_last.

Verification
REQ-034 Send "abc" (0x61,0x62,0x63, last on 0x63) -> one msg_valid pulse, byte_valid=3, msg_word[439:416]=0x616263, remaining bits 0, trunc_o=0.
REQ-035 Send 55 bytes 0x00..0x36 with last on byte 55 -> byte_valid=55, msg_word[7:0]=0x36, trunc_o=0.
REQ-036 Send 60 bytes with last on byte 60 -> trunc_o=1, byte_valid=55, bytes 56..60 discarded, exactly one msg_valid pulse after byte 60.
REQ-037 Single byte 0xFF with in_last=1, then a second message offered before hash_done -> in_ready=0 until the cycle after hash_done; the second message's msg_word has no 0xFF remnant.
REQ-038 Drop rst_n after 10 of 20 bytes -> all outputs return to their reset values immediately; no msg_valid pulse; a subsequent "abc" is packed correctly.
REQ-039 With SHA_MSG_TIMEOUT_EN defined and TIMEOUT_CYC=16, send 4 bytes without last and then idle -> msg_valid pulses 17 cycles after the 4th byte, with byte_valid=4.
